// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: rebuilds BCD digits from a multiplexed 7-segment bus.
// Snoops sseg/digit (both active-low) and publishes one word per complete scan.
//
// Ports:
//   clk, reset (async, active-low)
//   sseg[7:0]            segments a..g in [6:0], dp in [7]
//   digit[NDIG-1:0]      strobes, at most one low
//   bcd_out[4*NDIG-1:0]  last complete frame (F = blank, E = undecodable)
//   dp_out[NDIG-1:0]     decimal points of the last frame
//   frame_valid          1-cycle pulse on publish
//   frame_err            1-cycle pulse when a partial frame is dropped
//   seg_err              sticky undecodable-pattern flag
// Build option: define DECODE_DP_EN to capture and publish decimal points.
module sseg_scan_decoder #(
  parameter int NDIG   = 8,
  parameter int SETTLE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          sseg,
  input  logic [NDIG-1:0]     digit,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [NDIG-1:0]     dp_out,
  output logic                frame_valid,
  output logic                frame_err,
  output logic                seg_err
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE);

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    DONE
  } state_e;

  // Returns {err, code}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h00:   r = 5'h0F;
      default: r = 5'h1E;
    endcase
    return r;
  endfunction

  // Strobe qualification
  logic [NDIG-1:0] act;
  logic            vld_in;
  logic [KW-1:0]   k_in;

  always_comb begin
    act    = ~digit;
    vld_in = ($countones(act) == 1);
    k_in   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (act[i]) k_in = KW'(i);
    end
  end

  // Active-high segment view; dp is masked off when not captured
  // so a toggling dp does not restart the settle run.
  logic [7:0] seg_in;
`ifdef DECODE_DP_EN
  assign seg_in = ~sseg;
`else
  logic unused_dp;
  assign unused_dp = sseg[7];
  assign seg_in    = {1'b0, ~sseg[6:0]};
`endif

  // Settle tracking
  logic            prv_vld_q;
  logic [KW-1:0]   prv_k_q;
  logic [7:0]      prv_seg_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            smpd_q, smpd_d;
  logic            same, fire;

  // cnt is the length of the current run of identical cycles,
  // so a change starts a new run of one.
  always_comb begin
    same = vld_in && prv_vld_q &&
           (k_in == prv_k_q) && (seg_in == prv_seg_q);
    cnt_d  = '0;
    smpd_d = 1'b0;
    if (same) begin
      cnt_d  = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
      smpd_d = smpd_q;
    end else if (vld_in) begin
      cnt_d = CW'(1);
    end
    fire = vld_in && (cnt_d == CMAX) && !smpd_d;
    if (fire) smpd_d = 1'b1;
  end

  // Registered sample
  logic            smp_vld_q;
  logic [KW-1:0]   smp_k_q;
  logic [4:0]      smp_dec_q;
  logic [4:0]      smp_dec_d;
  assign smp_dec_d = decode(seg_in[6:0]);
`ifdef DECODE_DP_EN
  logic            smp_dp_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prv_vld_q <= 1'b0;
      prv_k_q   <= '0;
      prv_seg_q <= '0;
      cnt_q     <= '0;
      smpd_q    <= 1'b0;
      smp_vld_q <= 1'b0;
      smp_k_q   <= '0;
      smp_dec_q <= '0;
`ifdef DECODE_DP_EN
      smp_dp_q  <= 1'b0;
`endif
    end else begin
      prv_vld_q <= vld_in;
      prv_k_q   <= k_in;
      prv_seg_q <= seg_in;
      cnt_q     <= cnt_d;
      smpd_q    <= smpd_d;
      smp_vld_q <= fire;
      smp_k_q   <= k_in;
      smp_dec_q <= smp_dec_d;
`ifdef DECODE_DP_EN
      smp_dp_q  <= seg_in[7];
`endif
    end
  end

  // Frame assembly
  state_e            state_q, state_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic              fv_q, fv_d;
  logic              fe_q, fe_d;
  logic              se_q, se_d;
  logic              hunt;
`ifdef DECODE_DP_EN
  logic [NDIG-1:0]   shdp_q, shdp_d;
  logic [NDIG-1:0]   dp_q, dp_d;
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    se_d     = se_q | (smp_vld_q & smp_dec_q[4]);
    hunt     = 1'b0;
`ifdef DECODE_DP_EN
    shdp_d   = shdp_q;
    dp_d     = dp_q;
`endif
    unique case (state_q)
      HUNT: hunt = 1'b1;
      COLLECT: begin
        if (smp_vld_q) begin
          if (mask_q[smp_k_q]) begin
            // Repeat before completion: drop and let this
            // same sample try to open a new frame.
            fe_d    = 1'b1;
            mask_d  = '0;
            state_d = HUNT;
            hunt    = 1'b1;
          end else begin
            shadow_d[{smp_k_q, 2'b00} +: 4] = smp_dec_q[3:0];
`ifdef DECODE_DP_EN
            shdp_d[smp_k_q] = smp_dp_q;
`endif
            mask_d[smp_k_q] = 1'b1;
            if (&mask_d) state_d = DONE;
          end
        end
      end
      DONE: begin
        bcd_d   = shadow_q;
`ifdef DECODE_DP_EN
        dp_d    = shdp_q;
`endif
        fv_d    = 1'b1;
        mask_d  = '0;
        state_d = HUNT;
        hunt    = 1'b1;
      end
      default: state_d = HUNT;
    endcase
    if (hunt && smp_vld_q && (smp_k_q == '0)) begin
      shadow_d[3:0] = smp_dec_q[3:0];
`ifdef DECODE_DP_EN
      shdp_d[0] = smp_dp_q;
`endif
      mask_d  = NDIG'(1);
      state_d = (&mask_d) ? DONE : COLLECT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      mask_q   <= '0;
      shadow_q <= {NDIG{4'hF}};
      bcd_q    <= {NDIG{4'hF}};
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
      se_q     <= 1'b0;
`ifdef DECODE_DP_EN
      shdp_q   <= '0;
      dp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
      se_q     <= se_d;
`ifdef DECODE_DP_EN
      shdp_q   <= shdp_d;
      dp_q     <= dp_d;
`endif
    end
  end

  assign bcd_out     = bcd_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign seg_err     = se_q;
`ifdef DECODE_DP_EN
  assign dp_out      = dp_q;
`else
  assign dp_out      = '0;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder: table-driven scans with a frame scoreboard,
// plus hand-written repeat, short-strobe, stuck and reset sequences.
module tb_sseg_scan_decoder;

  localparam int NDIG   = 8;
  localparam int SETTLE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        sseg;
  logic [NDIG-1:0]   digit;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   dp_out;
  logic              frame_valid;
  logic              frame_err;
  logic              seg_err;

  sseg_scan_decoder #(
    .NDIG  (NDIG),
    .SETTLE(SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sseg       (sseg),
    .digit      (digit),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .seg_err    (seg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] digs;
    logic [7:0]  dps;
    logic [31:0] exp_bcd;
    logic [7:0]  exp_dp;
    logic        exp_se;
  } vec_t;

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  dp;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];

  int checks = 0;
  int fails = 0;
  int fv_seen = 0;
  int ferr_seen = 0;
  int last_fv = 0;
  int d7_start = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Digit value -> {dp, a..g}; F = blank, E = illegal pattern 0x49.
  function automatic logic [63:0] mkpat(input logic [31:0] d,
                                        input logic [7:0] dp);
    logic [63:0] r;
    logic [6:0]  s;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      case (d[4*i +: 4])
        4'h0: s = 7'h3F;
        4'h1: s = 7'h06;
        4'h2: s = 7'h5B;
        4'h3: s = 7'h4F;
        4'h4: s = 7'h66;
        4'h5: s = 7'h6D;
        4'h6: s = 7'h7D;
        4'h7: s = 7'h07;
        4'h8: s = 7'h7F;
        4'h9: s = 7'h6F;
        4'hF: s = 7'h00;
        default: s = 7'h49;
      endcase
      r[8*i +: 8] = {dp[i], s};
    end
    return r;
  endfunction

  function automatic logic [7:0] edp(input logic [7:0] dp);
`ifdef DECODE_DP_EN
    return dp;
`else
    return dp & 8'h00;
`endif
  endfunction

  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    if (frame_valid) begin
      exp_t e;
      fv_seen++;
      last_fv = cyc;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_frame got=%0h exp=none", bcd_out);
      end else begin
        e = sb.pop_front();
        chk("frame_bcd", 64'(bcd_out), 64'(e.bcd));
        chk("frame_dp", 64'(dp_out), 64'(e.dp));
      end
    end
  end

  task automatic drive_digit(input int k, input logic [7:0] p,
                             input int hold);
    digit = ~(NDIG'(1) << k);
    sseg  = ~p;
    repeat (hold) @(posedge clk);
    #1;
    digit = '1;
    sseg  = '1;
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [63:0] pat, input int hold);
    for (int k = 0; k < NDIG; k++) begin
      if (k == NDIG - 1) d7_start = cyc;
      drive_digit(k, pat[8*k +: 8], hold);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.bcd = v.exp_bcd;
    e.dp  = v.exp_dp;
    sb.push_back(e);
  endtask

  initial begin
    int fv0, fe0;
    tbl[0] = '{32'h87654321, 8'h00, 32'h87654321, edp(8'h00), 1'b0};
    tbl[1] = '{32'h76543210, 8'h00, 32'h76543210, edp(8'h00), 1'b0};
    tbl[2] = '{32'h23456789, 8'h04, 32'h23456789, edp(8'h04), 1'b0};
    tbl[3] = '{32'hF9F0F5FF, 8'h20, 32'hF9F0F5FF, edp(8'h20), 1'b0};
    tbl[4] = '{32'h1234E678, 8'h00, 32'h1234E678, edp(8'h00), 1'b1};
    tbl[5] = '{32'h00000000, 8'h81, 32'h00000000, edp(8'h81), 1'b1};

    reset = 1'b0;
    digit = '1;
    sseg  = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", 64'(bcd_out), 64'hFFFFFFFF);
    chk("rst_dp", 64'(dp_out), 64'd0);
    chk("rst_flags", 64'({frame_valid, frame_err, seg_err}), 64'd0);
    reset = 1'b1;

    // Idle bus
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_bcd", 64'(bcd_out), 64'hFFFFFFFF);
    chk("idle_fv", 64'(fv_seen), 64'd0);
    chk("idle_fe", 64'(ferr_seen), 64'd0);

    // Table scans, 8 cycles per digit with 1-cycle gaps
    for (int i = 0; i < 6; i++) begin
      push(tbl[i]);
      scan(mkpat(tbl[i].digs, tbl[i].dps), 8);
      drain();
      chk("latency", 64'(last_fv - d7_start), 64'(SETTLE + 2));
      chk("seg_err", 64'(seg_err), 64'(tbl[i].exp_se));
      chk("fv_count", 64'(fv_seen), 64'(i + 1));
    end

    // Repeat before completion: 0,1,2,1
    fv0 = fv_seen;
    fe0 = ferr_seen;
    for (int k = 0; k < 3; k++)
      drive_digit(k, mkpat(tbl[0].digs, 8'h00) >> (8 * k), 8);
    drive_digit(1, mkpat(tbl[0].digs, 8'h00) >> 8, 8);
    repeat (5) @(posedge clk);
    #1;
    chk("rep_fe", 64'(ferr_seen - fe0), 64'd1);
    chk("rep_fv", 64'(fv_seen - fv0), 64'd0);
    chk("rep_hold", 64'(bcd_out), 64'(tbl[5].exp_bcd));
    push(tbl[0]);
    scan(mkpat(tbl[0].digs, tbl[0].dps), 8);
    drain();

    // Strobes one cycle too short, then exactly SETTLE
    fv0 = fv_seen;
    fe0 = ferr_seen;
    scan(mkpat(tbl[1].digs, tbl[1].dps), SETTLE - 1);
    repeat (10) @(posedge clk);
    #1;
    chk("short_fv", 64'(fv_seen - fv0), 64'd0);
    chk("short_fe", 64'(ferr_seen - fe0), 64'd0);
    chk("short_bcd", 64'(bcd_out), 64'(tbl[0].exp_bcd));
    push(tbl[1]);
    scan(mkpat(tbl[1].digs, tbl[1].dps), SETTLE);
    drain();
    chk("min_latency", 64'(last_fv - d7_start), 64'(SETTLE + 2));

    // Stuck on digit 0: one sample, no frame, no error
    fv0 = fv_seen;
    fe0 = ferr_seen;
    drive_digit(0, 8'h3F, 100);
    chk("stuck_fv", 64'(fv_seen - fv0), 64'd0);
    chk("stuck_fe", 64'(ferr_seen - fe0), 64'd0);

    // Next digit 0 is a repeat of the stuck sample; then reset mid-frame
    for (int k = 0; k < 5; k++)
      drive_digit(k, mkpat(tbl[4].digs, 8'h00) >> (8 * k), 8);
    chk("restart_fe", 64'(ferr_seen - fe0), 64'd1);
    chk("pre_rst_se", 64'(seg_err), 64'd1);
    digit = ~(NDIG'(1) << 5);
    sseg  = ~8'h7D;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_bcd", 64'(bcd_out), 64'hFFFFFFFF);
    chk("mid_rst_dp", 64'(dp_out), 64'd0);
    chk("mid_rst_flags",
        64'({frame_valid, frame_err, seg_err}), 64'd0);
    digit = '1;
    sseg  = '1;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh frame after reset, dp on digit 2
    fv0 = fv_seen;
    push(tbl[2]);
    scan(mkpat(tbl[2].digs, tbl[2].dps), 8);
    drain();
    chk("post_rst_fv", 64'(fv_seen - fv0), 64'd1);
    chk("post_rst_se", 64'(seg_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
